// File: rtl/dmem_responder_if.sv
// Load/store port bundle between the pipeline (master) and dmem_responder (slave).
interface dmem_responder_if;
   logic        req_i;
   logic        we_i;
   logic [15:0] adr_i;
   logic [31:0] wd_i;
   logic [1:0]  mem_data_sel_i;
   logic        ready_o;
   logic [31:0] rdata_o;
   logic        err_o;

   modport master (
      output req_i, we_i, adr_i, wd_i, mem_data_sel_i,
      input  ready_o, rdata_o, err_o
   );

   modport slave (
      input  req_i, we_i, adr_i, wd_i, mem_data_sel_i,
      output ready_o, rdata_o, err_o
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory serving byte/half/word loads and read-modify-write stores.
// Optional feature: define DMEM_MISALIGN_CHECK_EN to turn misaligned half/word accesses into errors.
module dmem_responder #(
   parameter logic [15:0] BASE_ADDR = 16'h4000,
   parameter int          AW        = 14
) (
   input logic              clk_i,
   input logic              reset_i,
   dmem_responder_if.slave  bus
);

   localparam logic [1:0] SEL_BYTE = 2'b00;
   localparam logic [1:0] SEL_HALF = 2'b01;
   localparam logic [1:0] SEL_RSVD = 2'b10;
   localparam logic [1:0] SEL_WORD = 2'b11;

   typedef enum logic [1:0] {IDLE, RD, WR, ERR} state_t;

   state_t          state_q, state_d;
   logic            we_q, we_d;
   logic [1:0]      sel_q, sel_d;
   logic [31:0]     wd_q, wd_d;
   logic [1:0]      off_q, off_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [31:0]     merge_q, merge_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [31:0]     rdWord_q;

   logic [31:0]     mem [0:(1<<AW)-1];

   logic [16:0]     diff;
   logic            belowBase;
   logic            aboveTop;
   logic            misalign;
   logic            illegal;
   logic [AW-1:0]   wordAddr;
   logic [31:0]     loadData;
   logic [31:0]     mergeWord;
   logic [15:0]     halfLane;
   logic [7:0]      byteLane;
   logic            ready;
   logic            err;
   logic            wrEn;
   logic [31:0]     wrData;

   // The extra top bit of the subtraction is the borrow, i.e. adr_i below BASE_ADDR.
   assign diff      = {1'b0, bus.adr_i} - {1'b0, BASE_ADDR};
   assign belowBase = diff[16];
   assign aboveTop  = (diff[15:0] >> (AW + 2)) != 16'd0;
   assign wordAddr  = diff[AW+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
   assign misalign = ((bus.mem_data_sel_i == SEL_HALF) && bus.adr_i[0]) ||
                     ((bus.mem_data_sel_i == SEL_WORD) && (bus.adr_i[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign illegal = (bus.mem_data_sel_i == SEL_RSVD) || belowBase || aboveTop || misalign;

   always_comb begin
      byteLane = rdWord_q[{off_q, 3'b000} +: 8];
      halfLane = off_q[1] ? rdWord_q[31:16] : rdWord_q[15:0];
      case (sel_q)
         SEL_BYTE: loadData = {{24{byteLane[7]}}, byteLane};
         SEL_HALF: loadData = {{16{halfLane[15]}}, halfLane};
         default:  loadData = rdWord_q;
      endcase
   end

   always_comb begin
      mergeWord = rdWord_q;
      if (sel_q == SEL_BYTE) begin
         mergeWord[{off_q, 3'b000} +: 8] = wd_q[7:0];
      end else begin
         mergeWord[{off_q[1], 4'b0000} +: 16] = wd_q[15:0];
      end
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      sel_d   = sel_q;
      wd_d    = wd_q;
      off_d   = off_q;
      addr_d  = addr_q;
      merge_d = merge_q;
      rdata_d = rdata_q;
      ready   = 1'b0;
      err     = 1'b0;
      wrEn    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_i) begin
               we_d   = bus.we_i;
               sel_d  = bus.mem_data_sel_i;
               wd_d   = bus.wd_i;
               off_d  = bus.adr_i[1:0];
               addr_d = wordAddr;
               if (illegal) begin
                  state_d = ERR;
               end else if (bus.we_i && (bus.mem_data_sel_i == SEL_WORD)) begin
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            if (we_q) begin
               merge_d = mergeWord;
               state_d = WR;
            end else begin
               ready   = 1'b1;
               rdata_d = loadData;
               state_d = IDLE;
            end
         end
         WR: begin
            ready   = 1'b1;
            wrEn    = 1'b1;
            state_d = IDLE;
         end
         ERR: begin
            ready   = 1'b1;
            err     = 1'b1;
            rdata_d = 32'd0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign wrData      = (sel_q == SEL_WORD) ? wd_q : merge_q;
   assign bus.ready_o = ready;
   assign bus.err_o   = err;
   assign bus.rdata_o = rdata_d;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         sel_q   <= 2'b00;
         wd_q    <= 32'd0;
         off_q   <= 2'b00;
         addr_q  <= '0;
         merge_q <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         wd_q    <= wd_d;
         off_q   <= off_d;
         addr_q  <= addr_d;
         merge_q <= merge_d;
         rdata_q <= rdata_d;
      end
   end

   // Write enable decodes the reset-cleared state, so an early reset cancels a pending write.
   always_ff @(posedge clk_i) begin
      if (wrEn) begin
         mem[addr_q] <= wrData;
      end
      if (state_q == IDLE) begin
         rdWord_q <= mem[wordAddr];
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: loads, stores, merges, errors, reset and back-to-back.
module tb_dmem_responder;

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst_n;
   int          checks;
   int          errors;
   logic [31:0] lastRdata;
   exp_t        sbQ[$];

   dmem_responder_if bus ();

   dmem_responder #(.BASE_ADDR(16'h4000), .AW(14)) dut (
      .clk_i   (clk),
      .reset_i (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one request and queues what the completion must look like.
   task automatic applyStimulus(input string tag, input logic we, input logic [15:0] adr,
                                input logic [31:0] wd, input logic [1:0] sel,
                                input logic [31:0] loadExp, input logic expErr,
                                input int baseLat, input bit b2b);
      exp_t e;
      if (!b2b) @(negedge clk);
      bus.req_i          = 1'b1;
      bus.we_i           = we;
      bus.adr_i          = adr;
      bus.wd_i           = wd;
      bus.mem_data_sel_i = sel;
      if (expErr)   lastRdata = 32'd0;
      else if (!we) lastRdata = loadExp;
      e.tag   = tag;
      e.rdata = lastRdata;
      e.err   = expErr;
      e.lat   = b2b ? baseLat + 1 : baseLat;
      sbQ.push_back(e);
   endtask

   task automatic checkOutput(input bit keepReq);
      exp_t e;
      int   cyc;
      bit   seen;
      cyc  = 0;
      seen = 1'b0;
      while (cyc < 20 && !seen) begin
         @(negedge clk);
         cyc++;
         seen = bus.ready_o;
      end
      e = sbQ.pop_front();
      checkVal({e.tag, " ready"}, 32'(seen), 32'd1);
      if (seen) begin
         checkVal({e.tag, " latency"}, 32'(cyc), 32'(e.lat));
         checkVal({e.tag, " err"}, 32'(bus.err_o), 32'(e.err));
         checkVal({e.tag, " rdata"}, bus.rdata_o, e.rdata);
      end
      if (!keepReq) bus.req_i = 1'b0;
   endtask

   initial begin
      checks             = 0;
      errors             = 0;
      lastRdata          = 32'd0;
      rst_n              = 1'b0;
      bus.req_i          = 1'b0;
      bus.we_i           = 1'b0;
      bus.adr_i          = 16'h0000;
      bus.wd_i           = 32'd0;
      bus.mem_data_sel_i = 2'b11;
      repeat (3) @(negedge clk);
      checkVal("reset ready", 32'(bus.ready_o), 32'd0);
      checkVal("reset err", 32'(bus.err_o), 32'd0);
      checkVal("reset rdata", bus.rdata_o, 32'd0);
      rst_n = 1'b1;

      $display("[TB] word round trip and range boundaries");
      applyStimulus("sw 4000", 1, 16'h4000, 32'hDEADBEEF, 2'b11, 0, 0, 1, 0); checkOutput(0);
      applyStimulus("lw 4000", 0, 16'h4000, 0, 2'b11, 32'hDEADBEEF, 0, 1, 0); checkOutput(0);
      applyStimulus("sw FFFC", 1, 16'hFFFC, 32'hCAFEF00D, 2'b11, 0, 0, 1, 0); checkOutput(0);
      applyStimulus("lw FFFC", 0, 16'hFFFC, 0, 2'b11, 32'hCAFEF00D, 0, 1, 0); checkOutput(0);

      $display("[TB] byte merge");
      applyStimulus("sw 4010", 1, 16'h4010, 32'h11223344, 2'b11, 0, 0, 1, 0); checkOutput(0);
      applyStimulus("sb 4012", 1, 16'h4012, 32'h000000AA, 2'b00, 0, 0, 2, 0); checkOutput(0);
      applyStimulus("lw 4010", 0, 16'h4010, 0, 2'b11, 32'h11AA3344, 0, 1, 0); checkOutput(0);

      $display("[TB] sign extension and half merge");
      applyStimulus("sw 4020", 1, 16'h4020, 32'h80FF7F01, 2'b11, 0, 0, 1, 0); checkOutput(0);
      applyStimulus("lb 4021", 0, 16'h4021, 0, 2'b00, 32'h0000007F, 0, 1, 0); checkOutput(0);
      applyStimulus("lb 4022", 0, 16'h4022, 0, 2'b00, 32'hFFFFFFFF, 0, 1, 0); checkOutput(0);
      applyStimulus("lh 4022", 0, 16'h4022, 0, 2'b01, 32'hFFFF80FF, 0, 1, 0); checkOutput(0);
      applyStimulus("sw0 4020", 1, 16'h4020, 32'h00000000, 2'b11, 0, 0, 1, 0); checkOutput(0);
      applyStimulus("sh 4022", 1, 16'h4022, 32'h0000BEEF, 2'b01, 0, 0, 2, 0); checkOutput(0);
      applyStimulus("lw 4020", 0, 16'h4020, 0, 2'b11, 32'hBEEF0000, 0, 1, 0); checkOutput(0);

      $display("[TB] error accesses");
      applyStimulus("lw 3FFC", 0, 16'h3FFC, 0, 2'b11, 0, 1, 1, 0); checkOutput(0);
      applyStimulus("lb 3FFF", 0, 16'h3FFF, 0, 2'b00, 0, 1, 1, 0); checkOutput(0);
      applyStimulus("sw 3FFC", 1, 16'h3FFC, 32'h0BADF00D, 2'b11, 0, 1, 1, 0); checkOutput(0);
      applyStimulus("sel10 ld", 0, 16'h4000, 0, 2'b10, 0, 1, 1, 0); checkOutput(0);
      applyStimulus("sel10 st", 1, 16'h4000, 32'h12345678, 2'b10, 0, 1, 1, 0); checkOutput(0);
      applyStimulus("lw 4000 kept", 0, 16'h4000, 0, 2'b11, 32'hDEADBEEF, 0, 1, 0); checkOutput(0);
`ifdef DMEM_MISALIGN_CHECK_EN
      applyStimulus("lh 4001", 0, 16'h4001, 0, 2'b01, 0, 1, 1, 0); checkOutput(0);
`else
      applyStimulus("lh 4001", 0, 16'h4001, 0, 2'b01, 32'hFFFFBEEF, 0, 1, 0); checkOutput(0);
`endif

      $display("[TB] reset during sub-word store");
      applyStimulus("sw 4040", 1, 16'h4040, 32'h12345678, 2'b11, 0, 0, 1, 0); checkOutput(0);
      applyStimulus("lw 4040", 0, 16'h4040, 0, 2'b11, 32'h12345678, 0, 1, 0); checkOutput(0);
      @(negedge clk);
      bus.req_i          = 1'b1;
      bus.we_i           = 1'b1;
      bus.adr_i          = 16'h4041;
      bus.wd_i           = 32'h00000055;
      bus.mem_data_sel_i = 2'b00;
      @(negedge clk);
      checkVal("sb in RD ready", 32'(bus.ready_o), 32'd0);
      rst_n     = 1'b0;
      bus.req_i = 1'b0;
      #1;
      checkVal("mid reset ready", 32'(bus.ready_o), 32'd0);
      checkVal("mid reset err", 32'(bus.err_o), 32'd0);
      checkVal("mid reset rdata", bus.rdata_o, 32'd0);
      lastRdata = 32'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      applyStimulus("lw 4040 after rst", 0, 16'h4040, 0, 2'b11, 32'h12345678, 0, 1, 0); checkOutput(0);

      $display("[TB] back-to-back loads");
      applyStimulus("b2b0", 0, 16'h4000, 0, 2'b11, 32'hDEADBEEF, 0, 1, 0); checkOutput(1);
      applyStimulus("b2b1", 0, 16'h4010, 0, 2'b11, 32'h11AA3344, 0, 1, 1); checkOutput(1);
      applyStimulus("b2b2", 0, 16'h4020, 0, 2'b11, 32'hBEEF0000, 0, 1, 1); checkOutput(1);
      applyStimulus("b2b3", 0, 16'h4012, 0, 2'b00, 32'hFFFFFFAA, 0, 1, 1); checkOutput(0);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
